inflation_accum: RTL and testbench
==================================

INFLATION_ACCUM -- requirements
Module: inflation_accum

Interface
REQ-001 The block SHALL provide parameter KERNEL_SIZE, default 3, meaning the number of kernel rows summed per output pixel.
REQ-002 The block SHALL provide parameter DATA_WIDTH, default 8, meaning the output pixel width.
REQ-003 The block SHALL provide parameter WEIGHT_WIDTH, default 8, meaning the kernel weight width.
REQ-004 The block SHALL provide parameter NORM_SHIFT, default 8, meaning the weight normalisation right shift.
REQ-005 The block SHALL provide port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-006 The block SHALL provide port rstn, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL provide port acc_clear, input, 1 bit, a synchronous discard of any partial accumulation.
REQ-008 The block SHALL provide port in_valid, input, 1 bit, indicating that a row partial sum is present.
REQ-009 The block SHALL provide port in_data, input, IN_W = DATA_WIDTH+WEIGHT_WIDTH+KERNEL_SIZE bits, the unsigned row sum from the upstream adder tree.
REQ-010 The block SHALL provide port in_ready, output, 1 bit, indicating that the block accepts a beat when in_valid and in_ready are both high.
REQ-011 The block SHALL provide port out_valid, output, 1 bit, indicating that out_data holds an inflated pixel.
REQ-012 The block SHALL provide port out_data, output, DATA_WIDTH bits, the scaled and clamped cost value.
REQ-013 The block SHALL provide port out_ready, input, 1 bit, the downstream acceptance signal.
REQ-014 The block SHALL provide port row_cnt, output, clog2(KERNEL_SIZE) bits, the number of rows accumulated for the current pixel.
REQ-015 The block SHALL provide port sat_flag, output, 1 bit, a sticky flag set whenever the output is clamped or saturated.

Function
REQ-016 The block SHALL treat an accepted beat as in_valid && in_ready && !acc_clear.
REQ-017 The block SHALL implement a two-state accumulator FSM with states ACC and EMIT.
REQ-018 In state ACC, each accepted beat SHALL add in_data into the accumulator acc, of width ACC_W = IN_W + clog2(KERNEL_SIZE), and SHALL increment row_cnt.
REQ-019 The first beat of each pixel (row_cnt = 0) SHALL load acc with in_data rather than add to it.
REQ-020 On the accepted beat at row_cnt = KERNEL_SIZE-1, the block SHALL move the final sum to the scale stage, reset row_cnt to 0, and enter EMIT for one cycle.
REQ-021 The block SHALL return from EMIT to ACC unconditionally after that one cycle.
REQ-022 The scale stage SHALL compute p = (sum × 251) >> (8+NORM_SHIFT) at full width, with no intermediate truncation.
REQ-023 The clamp stage SHALL produce out_data = min(p, LIMIT), with LIMIT defined in REQ-035 and REQ-036, and SHALL set sat_flag when p > LIMIT.
REQ-024 The pipeline SHALL consist of an accumulate stage, a scale register, and an output register.
REQ-025 The latency from the accepted last row at cycle N to out_valid high SHALL be cycle N+2 when there is no backpressure.
REQ-026 The handshake SHALL follow valid/ready rules: out_data and out_valid SHALL stay stable while out_valid && !out_ready.
REQ-027 Each pipeline stage SHALL advance only when the stage after it is empty or being consumed in the same cycle.
REQ-028 in_ready SHALL be low only when the scale register is full and cannot advance; full throughput of one row per cycle SHALL be sustained while out_ready = 1.
REQ-029 acc_clear SHALL zero acc and row_cnt and SHALL leave the scale and output stages untouched.
REQ-030 When acc_clear and in_valid are high in the same cycle, acc_clear SHALL win and the beat SHALL be dropped.
REQ-031 sat_flag SHALL be cleared only by reset.

Reset
REQ-032 On rstn low, asynchronously, the block SHALL set acc = 0, row_cnt = 0, state = ACC, scale-stage valid = 0, out_valid = 0, out_data = 0, and sat_flag = 0.
REQ-033 While in reset, in_ready SHALL be 0, and it SHALL become 1 on the first clock after rstn deasserts.
REQ-034 A reset asserted mid-pixel or mid-output SHALL discard all in-flight data without emitting a partial pixel.

Configuration
REQ-035 When macro INFLATION_CLAMP_EN is defined, LIMIT SHALL be 253, so that inflation never produces the lethal or unknown codes 254 and 255.
REQ-036 When INFLATION_CLAMP_EN is undefined, LIMIT SHALL be 2^DATA_WIDTH-1 (255), giving plain saturation.

Structure
REQ-037 A shared package inflation_pkg SHALL hold GAIN_FACTOR = 251, GAIN_SHIFT = 8, LETHAL_LIMIT = 253, and the IN_W and ACC_W width functions.
REQ-038 The scale and clamp logic SHALL be one sub-module, inflation_scale_clamp, which is combinational and instantiated between the scale register and the output register.

Verification
REQ-039 The bench SHALL drive rows 1000, 2000, 3000 back-to-back with out_ready = 1 and SHALL check out_data = 22 at cycle N+2 and sat_flag = 0.
REQ-040 The bench SHALL drive rows 32768 ×3 and SHALL check out_data = 253 with the macro defined and 255 without it, and sat_flag = 1 in both cases.
REQ-041 The bench SHALL drive rows 22107, 22107, 22108 (sum 66322, p = 254) and SHALL check 253 plus sat_flag with the macro defined, and 254 with no flag without it.
REQ-042 The bench SHALL hold out_ready = 0 while streaming 9 rows, and SHALL check that in_ready drops, the first pixel holds stable, and no pixel is lost after out_ready rises.
REQ-043 The bench SHALL send 2 rows, pulse acc_clear together with a third valid row, then send rows 0, 0, 0, and SHALL check that a single output equal to 0 is produced.
REQ-044 The bench SHALL assert rstn low after 1 row of a pixel and during an out_valid hold, and SHALL check that all outputs read 0 immediately and that the next full pixel computes correctly.

Source files
------------

// File: rtl/inflation_pkg.sv
// Shared constants, width helpers and FSM state type for the inflation accumulator.
package inflation_pkg;

  localparam int GAIN_FACTOR  = 251;
  localparam int GAIN_SHIFT   = 8;
  localparam int LETHAL_LIMIT = 253;

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } acc_state_e;

  function automatic int in_w(input int data_w, input int weight_w, input int kernel);
    return data_w + weight_w + kernel;
  endfunction

  function automatic int acc_w(input int data_w, input int weight_w, input int kernel);
    return in_w(data_w, weight_w, kernel) + $clog2(kernel);
  endfunction

  // Keeps the row counter at least one bit wide for a degenerate 1-row kernel.
  function automatic int cnt_w(input int kernel);
    return (kernel > 1) ? $clog2(kernel) : 1;
  endfunction

endpackage

// File: rtl/inflation_scale_clamp.sv
// Combinational gain/shift of the kernel sum followed by clamping to LIMIT.
module inflation_scale_clamp
  import inflation_pkg::*;
#(
  parameter int ACC_W      = 21,
  parameter int DATA_WIDTH = 8,
  parameter int NORM_SHIFT = 8,
  parameter int LIMIT      = 255
) (
  input  logic [ACC_W-1:0]      sum_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sat_o
);

  // Product is kept at full width so the shift never drops significant bits.
  localparam int PROD_W = ACC_W + 8;
  localparam int SHIFT  = GAIN_SHIFT + NORM_SHIFT;

  logic [PROD_W-1:0] prod;
  logic [PROD_W-1:0] scaled;

  assign prod   = PROD_W'(sum_i) * PROD_W'(GAIN_FACTOR);
  assign scaled = prod >> SHIFT;
  assign sat_o  = (scaled > PROD_W'(LIMIT));
  assign data_o = sat_o ? DATA_WIDTH'(LIMIT) : scaled[DATA_WIDTH-1:0];

endmodule

// File: rtl/inflation_accum.sv
// Row-sum accumulator with scale/clamp pipeline; INFLATION_CLAMP_EN limits output to 253.
module inflation_accum
  import inflation_pkg::*;
#(
  parameter int  KERNEL_SIZE  = 3,
  parameter int  DATA_WIDTH   = 8,
  parameter int  WEIGHT_WIDTH = 8,
  parameter int  NORM_SHIFT   = 8,
  localparam int IN_W         = in_w(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE),
  localparam int ACC_W        = acc_w(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE),
  localparam int CNT_W        = cnt_w(KERNEL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  acc_clear,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      row_cnt,
  output logic                  sat_flag
);

`ifdef INFLATION_CLAMP_EN
  localparam int LIMIT = LETHAL_LIMIT;
`else
  localparam int LIMIT = (1 << DATA_WIDTH) - 1;
`endif

  acc_state_e            state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]      row_cnt_q, row_cnt_d;
  logic                  rdy_en_q;
  logic [ACC_W-1:0]      sum_q, sum_d;
  logic                  scale_vld_q, scale_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  sat_q, sat_d;

  logic                  scale_adv;
  logic                  beat;
  logic                  last_row;
  logic [ACC_W-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0] clamp_data;
  logic                  clamp_sat;

  // in_ready stays low in reset and for the first edge after it via rdy_en_q.
  assign scale_adv = scale_vld_q && (!out_vld_q || out_ready);
  assign in_ready  = rdy_en_q && (!scale_vld_q || scale_adv);
  assign beat      = in_valid && in_ready && !acc_clear;
  assign last_row  = (row_cnt_q == CNT_W'(KERNEL_SIZE - 1));
  assign acc_sum   = (row_cnt_q == '0) ? ACC_W'(in_data) : acc_q + ACC_W'(in_data);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (beat && last_row) state_d = EMIT;
      EMIT:    state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    sum_d       = sum_q;
    scale_vld_d = scale_vld_q && !scale_adv;
    if (acc_clear) begin
      acc_d     = '0;
      row_cnt_d = '0;
    end else if (beat) begin
      if (last_row) begin
        sum_d       = acc_sum;
        scale_vld_d = 1'b1;
        acc_d       = '0;
        row_cnt_d   = '0;
      end else begin
        acc_d     = acc_sum;
        row_cnt_d = row_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    out_vld_d  = out_vld_q && !out_ready;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    if (scale_adv) begin
      out_vld_d  = 1'b1;
      out_data_d = clamp_data;
      sat_d      = sat_q | clamp_sat;
    end
  end

  inflation_scale_clamp #(
    .ACC_W      (ACC_W),
    .DATA_WIDTH (DATA_WIDTH),
    .NORM_SHIFT (NORM_SHIFT),
    .LIMIT      (LIMIT)
  ) u_scale_clamp (
    .sum_i  (sum_q),
    .data_o (clamp_data),
    .sat_o  (clamp_sat)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ACC;
      acc_q       <= '0;
      row_cnt_q   <= '0;
      rdy_en_q    <= 1'b0;
      sum_q       <= '0;
      scale_vld_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      row_cnt_q   <= row_cnt_d;
      rdy_en_q    <= 1'b1;
      sum_q       <= sum_d;
      scale_vld_q <= scale_vld_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign row_cnt   = row_cnt_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_inflation_accum.sv
// Self-checking bench for inflation_accum against a sum-and-scale reference model.
module tb_inflation_accum;

  localparam int KS   = 3;
  localparam int DW   = 8;
  localparam int WW   = 8;
  localparam int NS   = 8;
  localparam int IN_W = DW + WW + KS;
  localparam int CW   = 2;

`ifdef INFLATION_CLAMP_EN
  localparam int   LIMIT    = 253;
  localparam int   LETH_EXP = 253;
  localparam logic LETH_SAT = 1'b1;
`else
  localparam int   LIMIT    = 255;
  localparam int   LETH_EXP = 254;
  localparam logic LETH_SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            acc_clear = 1'b0;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b0;
  logic [CW-1:0]   row_cnt;
  logic            sat_flag;

  int total = 0;
  int bad   = 0;

  int    exp_q[$];
  longint m_sum;
  int    m_cnt;
  bit    m_sat;

  always #5 clk = ~clk;

  inflation_accum dut (
    .clk       (clk),
    .rstn      (rstn),
    .acc_clear (acc_clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .row_cnt   (row_cnt),
    .sat_flag  (sat_flag)
  );

  // Reference: a pixel is the plain sum of KS accepted rows, scaled by 251/2^(8+NS), clamped.
  task automatic model_beat(input longint d);
    longint p;
    m_sum = (m_cnt == 0) ? d : m_sum + d;
    m_cnt++;
    if (m_cnt == KS) begin
      p = (m_sum * 251) >> (8 + NS);
      if (p > LIMIT) m_sat = 1'b1;
      exp_q.push_back((p > LIMIT) ? LIMIT : int'(p));
      m_cnt = 0;
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_sum = 0;
    m_sat = 1'b0;
    exp_q.delete();
  endtask

  // Drives one cycle from a negedge and reports what the handshakes will do at the posedge.
  task automatic cycle(input logic v, input logic [IN_W-1:0] d, input logic ordy, input logic clr,
                       output logic beat, output logic xfer, output logic ov, output logic ir,
                       output logic [DW-1:0] od);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    acc_clear = clr;
    #1;
    beat = v && in_ready && !clr;
    xfer = out_valid && ordy;
    ov   = out_valid;
    ir   = in_ready;
    od   = out_data;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends three rows with out_ready high and returns the pixel that appears.
  task automatic run_pixel(input int r0, input int r1, input int r2, output logic got,
                           output logic [DW-1:0] val);
    logic b, x, ov, ir;
    logic [DW-1:0] od;
    int rows[3];
    int i;
    rows = '{r0, r1, r2};
    i = 0;
    got = 1'b0;
    val = '0;
    for (int c = 0; c < 10 && i < 3; c++) begin
      cycle(1'b1, IN_W'(rows[i]), 1'b1, 1'b0, b, x, ov, ir, od);
      if (b) i++;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        val = out_data;
      end
      @(negedge clk);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, b, x, ov, ir, od);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total += 5;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
    if (row_cnt !== '0) begin bad++; $display("FAIL rst_row_cnt: got %0d want 0", row_cnt); end
    if (sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat: got %0b want 0", sat_flag); end
    rstn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_early: got %0b want 0", in_ready); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_up: got %0b want 1", in_ready); end
    model_reset();
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    logic b0, b1, b2, x, ov, ir;
    logic [DW-1:0] od;
    cycle(1'b1, IN_W'(1000), 1'b1, 1'b0, b0, x, ov, ir, od);
    cycle(1'b1, IN_W'(2000), 1'b1, 1'b0, b1, x, ov, ir, od);
    cycle(1'b1, IN_W'(3000), 1'b1, 1'b0, b2, x, ov, ir, od);
    in_valid = 1'b0;
    total++;
    if (!(b0 && b1 && b2)) begin bad++; $display("FAIL basic_accept: got %0b%0b%0b want 111", b0, b1, b2); end
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_n1: out_valid got %0b want 0", out_valid); end
    @(negedge clk);
    #1;
    total += 3;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_n2_valid: got %0b want 1", out_valid); end
    if (out_data !== 8'd22) begin bad++; $display("FAIL basic_n2_data: got %0d want 22", out_data); end
    if (sat_flag !== 1'b0) begin bad++; $display("FAIL basic_sat: got %0b want 0", sat_flag); end
    @(negedge clk);
    $display("test_basic: pixel=%0d", out_data);
  endtask

  task automatic test_lethal();
    logic got;
    logic [DW-1:0] val;
    run_pixel(22107, 22107, 22108, got, val);
    total += 3;
    if (got !== 1'b1) begin bad++; $display("FAIL lethal_timeout: got no pixel, want one"); end
    if (val !== DW'(LETH_EXP)) begin bad++; $display("FAIL lethal_data: got %0d want %0d", val, LETH_EXP); end
    if (sat_flag !== LETH_SAT) begin bad++; $display("FAIL lethal_sat: got %0b want %0b", sat_flag, LETH_SAT); end
    $display("test_lethal: pixel=%0d sat=%0b", val, sat_flag);
  endtask

  task automatic test_saturate();
    logic got;
    logic [DW-1:0] val;
    run_pixel(32768, 32768, 32768, got, val);
    total += 3;
    if (got !== 1'b1) begin bad++; $display("FAIL sat_timeout: got no pixel, want one"); end
    if (val !== DW'(LIMIT)) begin bad++; $display("FAIL sat_data: got %0d want %0d", val, LIMIT); end
    if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_flag: got %0b want 1", sat_flag); end
    $display("test_saturate: pixel=%0d sat=%0b", val, sat_flag);
  endtask

  task automatic test_backpressure();
    logic b, x, ov, ir;
    logic [DW-1:0] od;
    logic [IN_W-1:0] rows[9];
    logic [DW-1:0] hold_data;
    int sent, npix, e;
    bit stall, held;
    for (int i = 0; i < 9; i++) rows[i] = IN_W'($urandom_range(0, 30000));
    sent = 0; npix = 0; stall = 0; held = 0; hold_data = '0;
    m_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 20; c++) begin
      cycle(sent < 9, rows[sent < 9 ? sent : 0], 1'b0, 1'b0, b, x, ov, ir, od);
      if (sent < 9 && !ir) stall = 1;
      if (b) begin model_beat(longint'(rows[sent])); sent++; end
      if (held) begin
        total++;
        if (!ov || od !== hold_data) begin
          bad++; $display("FAIL bp_hold: got valid=%0b data=%0d want valid=1 data=%0d", ov, od, hold_data);
        end
      end else if (ov) begin
        held = 1; hold_data = od;
      end
    end
    total += 2;
    if (!stall) begin bad++; $display("FAIL bp_stall: in_ready never dropped, want drop"); end
    if (!held) begin bad++; $display("FAIL bp_held: got no held pixel, want one"); end
    for (int c = 0; c < 60 && (sent < 9 || exp_q.size() > 0); c++) begin
      cycle(sent < 9, rows[sent < 9 ? sent : 0], 1'b1, 1'b0, b, x, ov, ir, od);
      if (b) begin model_beat(longint'(rows[sent])); sent++; end
      if (x) begin
        total++; npix++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL bp_pixel: got %0d want no pixel", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e[DW-1:0]) begin bad++; $display("FAIL bp_pixel: got %0d want %0d", od, e); end
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (npix != 3 || sent != 9) begin bad++; $display("FAIL bp_count: got %0d pixels %0d rows want 3 and 9", npix, sent); end
    $display("test_backpressure: pixels=%0d", npix);
  endtask

  task automatic test_clear();
    logic b, x, ov, ir;
    logic [DW-1:0] od;
    logic [IN_W-1:0] rows[5];
    int i, npix, e;
    rows = '{IN_W'(5000), IN_W'(6000), '0, '0, '0};
    npix = 0;
    i = 0;
    for (int c = 0; c < 10 && i < 2; c++) begin
      cycle(1'b1, rows[i], 1'b1, 1'b0, b, x, ov, ir, od);
      if (b) begin model_beat(longint'(rows[i])); i++; end
    end
    cycle(1'b1, IN_W'(7000), 1'b1, 1'b1, b, x, ov, ir, od);
    m_cnt = 0; m_sum = 0;
    total++;
    if (row_cnt !== '0) begin bad++; $display("FAIL clr_row_cnt: got %0d want 0", row_cnt); end
    for (int c = 0; c < 16 && (i < 5 || exp_q.size() > 0); c++) begin
      cycle(i < 5, rows[i < 5 ? i : 0], 1'b1, 1'b0, b, x, ov, ir, od);
      if (b) begin model_beat(longint'(rows[i])); i++; end
      if (x) begin
        total++; npix++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL clr_pixel: got %0d want no pixel", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e[DW-1:0]) begin bad++; $display("FAIL clr_pixel: got %0d want %0d", od, e); end
        end
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total += 2;
    if (npix != 1) begin bad++; $display("FAIL clr_count: got %0d pixels want 1", npix); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_extra: out_valid got %0b want 0", out_valid); end
    $display("test_clear: pixels=%0d", npix);
  endtask

  task automatic test_reset_mid();
    logic b, x, ov, ir;
    logic [DW-1:0] od;
    logic [IN_W-1:0] rows[3];
    int i, npix, e;
    bit seen;
    for (int k = 0; k < 3; k++) rows[k] = IN_W'($urandom_range(0, 40000));
    cycle(1'b1, rows[0], 1'b1, 1'b0, b, x, ov, ir, od);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total += 5;
    if (row_cnt !== '0) begin bad++; $display("FAIL mid_row_cnt: got %0d want 0", row_cnt); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %0b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL mid_out_data: got %0d want 0", out_data); end
    if (sat_flag !== 1'b0) begin bad++; $display("FAIL mid_sat: got %0b want 0", sat_flag); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0b want 0", in_ready); end
    @(negedge clk); rstn = 1'b1; model_reset(); @(negedge clk);
    i = 0; seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      cycle(i < 3, rows[i < 3 ? i : 0], 1'b0, 1'b0, b, x, ov, ir, od);
      if (b) i++;
      if (ov) seen = 1;
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    total += 3;
    if (!seen) begin bad++; $display("FAIL mid_hold_timeout: got no held pixel, want one"); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_hold_valid: got %0b want 0", out_valid); end
    if (out_data !== '0) begin bad++; $display("FAIL mid_hold_data: got %0d want 0", out_data); end
    @(negedge clk); rstn = 1'b1; model_reset(); @(negedge clk);
    i = 0; npix = 0;
    for (int c = 0; c < 16 && (i < 3 || exp_q.size() > 0); c++) begin
      cycle(i < 3, rows[i < 3 ? i : 0], 1'b1, 1'b0, b, x, ov, ir, od);
      if (b) begin model_beat(longint'(rows[i])); i++; end
      if (x) begin
        total++; npix++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL mid_pixel: got %0d want no pixel", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e[DW-1:0]) begin bad++; $display("FAIL mid_pixel: got %0d want %0d", od, e); end
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (npix != 1) begin bad++; $display("FAIL mid_count: got %0d pixels want 1", npix); end
    $display("test_reset_mid: pixels=%0d", npix);
  endtask

  task automatic test_random();
    logic b, x, ov, ir, v, ordy, clr;
    logic [DW-1:0] od;
    logic [IN_W-1:0] d;
    int npix, e;
    npix = 0;
    for (int c = 0; c < 400; c++) begin
      total++;
      if (row_cnt !== CW'(m_cnt)) begin bad++; $display("FAIL rnd_row_cnt: got %0d want %0d", row_cnt, m_cnt); end
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 31) == 0);
      d    = IN_W'($urandom_range(0, 50000));
      cycle(v, d, ordy, clr, b, x, ov, ir, od);
      if (clr) begin m_cnt = 0; m_sum = 0; end
      else if (b) model_beat(longint'(d));
      if (x) begin
        total++; npix++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_pixel: got %0d want no pixel", od); end
        else begin
          e = exp_q.pop_front();
          if (od !== e[DW-1:0]) begin bad++; $display("FAIL rnd_pixel: got %0d want %0d", od, e); end
        end
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, b, x, ov, ir, od);
      if (x) begin
        total++; npix++;
        e = exp_q.pop_front();
        if (od !== e[DW-1:0]) begin bad++; $display("FAIL rnd_drain: got %0d want %0d", od, e); end
      end
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rnd_lost: got %0d pixels missing want 0", exp_q.size()); end
    if (sat_flag !== m_sat) begin bad++; $display("FAIL rnd_sat: got %0b want %0b", sat_flag, m_sat); end
    $display("test_random: pixels=%0d sat=%0b", npix, sat_flag);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_lethal();
    test_saturate();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
